// File: rtl/pp_button_ctrl_if.sv
// Play/pause button front-end signal bundle: raw button in, run/tick/clear/debounced level out.
interface pp_button_ctrl_if;
    logic pp;
    logic run;
    logic tick;
    logic clr;
    logic pp_db;

    modport master (output pp, input run, tick, clr, pp_db);
    modport slave  (input pp, output run, tick, clr, pp_db);
endinterface

// File: rtl/pp_button_ctrl.sv
// Play/pause front end: synchronise + debounce the button, toggle run per press, gated 10 Hz tick.
// Optional long-press clear is built when LONG_PRESS_CLR_EN is defined.
module pp_button_ctrl #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int TICK_DIV    = 10_000_000,
    parameter int LONG_CYCLES = 200_000_000
) (
    input  logic          clk,
    input  logic          reset,
    pp_button_ctrl_if.slave bus
);

    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              s1;
    logic              s2;
    logic              pp_db;
    logic              run;
    logic              tick;
    logic [DB_W-1:0]   db_cnt;
    logic [TICK_W-1:0] div_cnt;

    logic              press;
    logic              wrap;
    logic              run_nxt;

`ifdef LONG_PRESS_CLR_EN
    localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

    logic              clr;
    logic [LONG_W-1:0] hold_cnt;
    logic              long_hit;

    // The clear fires only on the step into the saturation value, so one per press.
    assign long_hit = pp_db && (hold_cnt == LONG_PRE);
`endif

    // A press is the accepted 0->1 update of the debounced level.
    always_comb begin
        press   = (s2 != pp_db) && (db_cnt == DB_LAST) && s2;
        wrap    = run && (div_cnt == TICK_LAST);
        run_nxt = press ? ~run : run;
`ifdef LONG_PRESS_CLR_EN
        if (long_hit) begin
            run_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            pp_db   <= 1'b0;
            run     <= 1'b0;
            tick    <= 1'b0;
            db_cnt  <= '0;
            div_cnt <= '0;
        end else begin
            s1 <= bus.pp;
            s2 <= s1;

            if (s2 == pp_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                pp_db  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            run <= run_nxt;
            // A wrap coinciding with the pause edge is swallowed rather than leaking a tick.
            tick <= wrap && run_nxt;

            if (run) begin
                div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            end
`ifdef LONG_PRESS_CLR_EN
            if (long_hit) begin
                div_cnt <= '0;
            end
`endif
        end
    end

`ifdef LONG_PRESS_CLR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            clr      <= 1'b0;
        end else begin
            if (!pp_db) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LONG_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            clr <= long_hit;
        end
    end

    assign bus.clr = clr;
`else
    logic unused_long;
    assign unused_long = LONG_CYCLES[0];
    assign bus.clr     = 1'b0;
`endif

    assign bus.run   = run;
    assign bus.tick  = tick;
    assign bus.pp_db = pp_db;

endmodule

// File: tb/tb_pp_button_ctrl.sv
// Bench for pp_button_ctrl: directed scenarios plus random button activity against a behavioural model.
module tb_pp_button_ctrl;

    localparam int DB = 4;
    localparam int TD = 5;
    localparam int LC = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic pp    = 1'b0;

    always #5 clk = ~clk;

    pp_button_ctrl_if bus ();
    assign bus.pp = pp;

    pp_button_ctrl #(
        .DB_CYCLES  (DB),
        .TICK_DIV   (TD),
        .LONG_CYCLES(LC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: button level is accepted after DB consecutive differing samples,
    // run flips per accepted press, and ticks land on every TD-th running cycle.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0, m_run = 1'b0, m_tick = 1'b0, m_clr = 1'b0;
    logic s2_hist[$];
    int   phase = 0;
    int   held  = 0;

    always @(posedge clk) begin : model
        logic o_s2, o_db, o_run, upd, long_hit, wrapped;
        int   prev_held;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_tick = 0; m_clr = 0;
            s2_hist.delete();
            phase = 0;
            held  = 0;
        end else begin
            o_s2  = m_s2;
            o_db  = m_db;
            o_run = m_run;
            s2_hist.push_back(o_s2);
            if (s2_hist.size() > DB) void'(s2_hist.pop_front());
            upd = (s2_hist.size() == DB);
            foreach (s2_hist[i]) if (s2_hist[i] == o_db) upd = 0;
            if (upd) s2_hist.delete();
            prev_held = held;
            held = o_db ? ((held < LC - 1) ? held + 1 : held) : 0;
`ifdef LONG_PRESS_CLR_EN
            long_hit = (held == LC - 1) && (prev_held != LC - 1);
`else
            long_hit = 0;
`endif
            m_run = long_hit ? 1'b0 : ((upd && o_s2) ? ~o_run : o_run);
            wrapped = 0;
            if (o_run) begin
                phase++;
                if (phase == TD) begin
                    phase   = 0;
                    wrapped = 1;
                end
            end
            if (long_hit) phase = 0;
            m_tick = wrapped && m_run;
            m_clr  = long_hit;
            if (upd) m_db = o_s2;
            m_s2 = m_s1;
            m_s1 = pp;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        pp    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d got run/tick/clr/pp_db=%b want 0000", i,
                         {bus.run, bus.tick, bus.clr, bus.pp_db});
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got run/tick/clr/pp_db=%b want 0000",
                     {bus.run, bus.tick, bus.clr, bus.pp_db});
        end
        pp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== {m_run, m_tick, m_clr, m_db}) begin
                errors++;
                $display("FAIL reset_settle t=%0t got %b want %b", $time,
                         {bus.run, bus.tick, bus.clr, bus.pp_db}, {m_run, m_tick, m_clr, m_db});
            end
        end
    endtask

    task automatic test_glitch();
        pp = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 2) pp = 1'b0;
            checks++;
            if ({bus.run, bus.pp_db} !== 2'b00) begin
                errors++;
                $display("FAIL glitch_reject cycle=%0d got run/pp_db=%b want 00", i, {bus.run, bus.pp_db});
            end
        end
        pp = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.run !== (i == 6)) begin
                errors++;
                $display("FAIL press_latency edge=%0d got run=%b want %b", i, bus.run, (i == 6));
            end
        end
        pp = 1'b0;
    endtask

    task automatic test_tick_cadence();
        int n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== ((i % TD) == 0)) begin
                errors++;
                $display("FAIL tick_cadence cycle=%0d got tick=%b want %b", i, bus.tick, ((i % TD) == 0));
            end
            if (bus.tick === 1'b1) n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL tick_count got %0d want 4", n);
        end
    endtask

    task automatic test_pause_resume();
        bit found = 0;
        int rise  = 0;
        for (int i = 0; i < 2 * TD && !found; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pause_wait_tick got no tick want tick within %0d cycles", 2 * TD);
        end
        @(negedge clk);
        pp = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.run, bus.tick} !== {(i < 7), (i == 5)}) begin
                errors++;
                $display("FAIL pause_edge cycle=%0d got run/tick=%b want %b", i, {bus.run, bus.tick},
                         {(i < 7), (i == 5)});
            end
        end
        pp = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.run, bus.tick} !== 2'b00) begin
                errors++;
                $display("FAIL paused cycle=%0d got run/tick=%b want 00", i, {bus.run, bus.tick});
            end
        end
        pp = 1'b1;
        for (int i = 1; i <= 10 && rise == 0; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1) rise = i;
        end
        pp = 1'b0;
        checks++;
        if (rise != 6) begin
            errors++;
            $display("FAIL resume_latency got %0d want 6", rise);
        end
        for (int j = 1; j <= TD; j++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (j == 3)) begin
                errors++;
                $display("FAIL resume_phase cycle=%0d got tick=%b want %b", j, bus.tick, (j == 3));
            end
        end
    endtask

    task automatic test_bouncy();
        int lv[10]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        int len[10] = '{2, 2, 2, 2, 7, 2, 2, 2, 2, 12};
        int   toggles = 0;
        logic prev;
        for (int i = 0; i < 10; i++) @(negedge clk);
        checks++;
        if (bus.run !== 1'b1) begin
            errors++;
            $display("FAIL bouncy_start got run=%b want 1", bus.run);
        end
        prev = bus.run;
        for (int s = 0; s < 10; s++) begin
            pp = lv[s][0];
            for (int c = 0; c < len[s]; c++) begin
                @(negedge clk);
                checks++;
                if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== {m_run, m_tick, m_clr, m_db}) begin
                    errors++;
                    $display("FAIL bouncy_model t=%0t got %b want %b", $time,
                             {bus.run, bus.tick, bus.clr, bus.pp_db}, {m_run, m_tick, m_clr, m_db});
                end
                if (bus.run !== prev) toggles++;
                prev = bus.run;
            end
        end
        checks++;
        if (toggles != 1 || bus.run !== 1'b0) begin
            errors++;
            $display("FAIL bouncy_toggle got toggles=%0d run=%b want 1 toggle run=0", toggles, bus.run);
        end
    endtask

    task automatic test_long_press();
        int rise = 0, clr_n = 0, clr_i = 0;
        pp = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== {m_run, m_tick, m_clr, m_db}) begin
                errors++;
                $display("FAIL long_model cycle=%0d got %b want %b", i,
                         {bus.run, bus.tick, bus.clr, bus.pp_db}, {m_run, m_tick, m_clr, m_db});
            end
            if (rise == 0 && bus.run === 1'b1) rise = i;
            if (bus.clr === 1'b1) begin
                clr_n++;
                clr_i = i;
                checks++;
                if (bus.run !== 1'b0) begin
                    errors++;
                    $display("FAIL long_clr_run got run=%b want 0", bus.run);
                end
`ifdef LONG_PRESS_CLR_EN
                checks++;
                if (dut.div_cnt !== '0) begin
                    errors++;
                    $display("FAIL long_clr_div got div_cnt=%0d want 0", dut.div_cnt);
                end
`endif
            end
        end
        pp = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        checks++;
        if (rise != 6) begin
            errors++;
            $display("FAIL long_rise got %0d want 6", rise);
        end
        checks++;
`ifdef LONG_PRESS_CLR_EN
        if (clr_n != 1 || clr_i != rise + LC - 1) begin
            errors++;
            $display("FAIL long_clr got count=%0d at=%0d want 1 at %0d", clr_n, clr_i, rise + LC - 1);
        end
`else
        if (clr_n != 0) begin
            errors++;
            $display("FAIL long_clr got count=%0d want 0", clr_n);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int rise = 0;
        reset = 1'b1;
        pp    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pp    = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        reset = 1'b1;
        pp    = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got run/tick/clr/pp_db=%b want 0000", {bus.run, bus.tick, bus.clr, bus.pp_db});
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        pp = 1'b1;
        for (int i = 1; i <= 10 && rise == 0; i++) begin
            @(negedge clk);
            if (bus.run === 1'b1) rise = i;
        end
        pp = 1'b0;
        checks++;
        if (rise != 6) begin
            errors++;
            $display("FAIL reset_mid_press got %0d want 6", rise);
        end
        for (int j = 1; j <= TD; j++) begin
            @(negedge clk);
            checks++;
            if (bus.tick !== (j == TD)) begin
                errors++;
                $display("FAIL reset_mid_phase cycle=%0d got tick=%b want %b", j, bus.tick, (j == TD));
            end
        end
    endtask

    task automatic test_random();
        logic prev_tick = 1'b0;
        for (int s = 0; s < 60; s++) begin
            pp    = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                @(negedge clk);
                reset = 1'b0;
                checks++;
                if ({bus.run, bus.tick, bus.clr, bus.pp_db} !== {m_run, m_tick, m_clr, m_db}) begin
                    errors++;
                    $display("FAIL random_model t=%0t got %b want %b", $time,
                             {bus.run, bus.tick, bus.clr, bus.pp_db}, {m_run, m_tick, m_clr, m_db});
                end
                checks++;
                if (bus.tick === 1'b1 && prev_tick === 1'b1) begin
                    errors++;
                    $display("FAIL tick_duty t=%0t got two consecutive ticks want single-cycle", $time);
                end
                prev_tick = bus.tick;
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_tick_cadence();
        test_pause_resume();
        test_bouncy();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
